mac_rx_align_chk: RTL and testbench

MAC_RX_ALIGN_CHK -- requirements
Module: mac_rx_align_chk

---
 rtl/mac_rx_align_chk_pkg.sv | 23 ++
 rtl/mac_rx_align_chk.sv | 179 +++++++++++++++++
 tb/tb_mac_rx_align_chk.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mac_rx_align_chk_pkg.sv
// -----------------------------------------------------------------------------
// mac_rx_align_chk_pkg
// Shared MAC DV/RTL definitions for the RX word-alignment checker: the
// alignment FSM state encoding and the width of its run-length counters.
// -----------------------------------------------------------------------------
package mac_rx_align_chk_pkg;

    // Width of the good/bad run counters and of the error counter.
    localparam int CNT_W = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_ZERO = cnt_t'(0);
    localparam cnt_t CNT_ONE  = cnt_t'(1);
    localparam cnt_t CNT_MAX  = cnt_t'((1 << CNT_W) - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } align_state_e;

endpackage : mac_rx_align_chk_pkg

// File: rtl/mac_rx_align_chk.sv
// -----------------------------------------------------------------------------
// mac_rx_align_chk
// Word-alignment checker on the MAC read side of the AIB RX FIFO. Every valid
// word must carry a marker (bit MARK_HI = 1, bit MARK_LO = 0). LOCK_CNT
// consecutive good words declare alignment, UNLOCK_CNT consecutive bad words
// drop it. While aligned, each bad word raises a one-cycle wa_error pulse that
// is also tallied in a saturating counter.
//
// Ports
//   rd_clk              in   sole clock (MAC read-side FIFO clock)
//   rst                 in   synchronous active-high reset
//   rx_transfer_en      in   adapter RX transfer enable, low forces IDLE
//   data_vld            in   data_out carries a valid word
//   data_out            in   RX FIFO read word (2*DWIDTH bits)
//   clr_err_cnt         in   single-cycle clear of wa_error_cnt
//   m_rxfifo_align_done out  alignment achieved (state is LOCKED)
//   wa_error            out  one-cycle pulse per bad marker while aligned
//   wa_error_cnt        out  saturating count of wa_error pulses
//   dout                out  registered copy of data_out
//   dout_vld            out  dout valid, only for words accepted while LOCKED
//
// LOCK_CNT and UNLOCK_CNT must lie in 1..15 (they are compared against 4-bit
// run counters).
// -----------------------------------------------------------------------------
module mac_rx_align_chk
    import mac_rx_align_chk_pkg::*;
#(
    parameter int DWIDTH     = 40,
    parameter int MARK_HI    = 2*DWIDTH-1,
    parameter int MARK_LO    = DWIDTH-1,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  rx_transfer_en,
    input  logic                  data_vld,
    input  logic [2*DWIDTH-1:0]   data_out,
    input  logic                  clr_err_cnt,
    output logic                  m_rxfifo_align_done,
    output logic                  wa_error,
    output logic [CNT_W-1:0]      wa_error_cnt,
    output logic [2*DWIDTH-1:0]   dout,
    output logic                  dout_vld
);

    localparam cnt_t LOCK_LIM   = cnt_t'(LOCK_CNT);
    localparam cnt_t UNLOCK_LIM = cnt_t'(UNLOCK_CNT);

    align_state_e        state_q, state_d;
    cnt_t                good_cnt_q, good_cnt_d;
    cnt_t                bad_cnt_q, bad_cnt_d;
    cnt_t                err_cnt_q, err_cnt_d;
    logic                wa_error_q, wa_error_d;
    logic                align_done_q;
    logic                dout_vld_q;
    logic [2*DWIDTH-1:0] dout_q;

    logic word_good_s;
    logic word_bad_s;
    cnt_t good_inc_s;
    cnt_t bad_inc_s;

    assign word_good_s = data_vld & data_out[MARK_HI] & ~data_out[MARK_LO];
    assign word_bad_s  = data_vld & ~word_good_s;
    assign good_inc_s  = good_cnt_q + CNT_ONE;
    assign bad_inc_s   = bad_cnt_q + CNT_ONE;

    // Alignment FSM next state, run counters and error pulse request.
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        wa_error_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_transfer_en) begin
                    state_d = ST_SEARCH;
                end else begin
                    state_d = ST_IDLE;
                end
                good_cnt_d = CNT_ZERO;
                bad_cnt_d  = CNT_ZERO;
            end
            ST_SEARCH: begin
                if (!rx_transfer_en) begin
                    state_d    = ST_IDLE;
                    good_cnt_d = CNT_ZERO;
                    bad_cnt_d  = CNT_ZERO;
                end else if (word_good_s) begin
                    if (good_inc_s == LOCK_LIM) begin
                        state_d    = ST_LOCKED;
                        good_cnt_d = CNT_ZERO;
                    end else begin
                        good_cnt_d = good_inc_s;
                    end
                end else if (word_bad_s) begin
                    good_cnt_d = CNT_ZERO;
                end else begin
                    // data_vld low: counters hold
                    good_cnt_d = good_cnt_q;
                end
            end
            ST_LOCKED: begin
                if (!rx_transfer_en) begin
                    state_d    = ST_IDLE;
                    good_cnt_d = CNT_ZERO;
                    bad_cnt_d  = CNT_ZERO;
                end else if (word_bad_s) begin
                    // The word that causes unlock still reports an error.
                    wa_error_d = 1'b1;
                    if (bad_inc_s == UNLOCK_LIM) begin
                        state_d    = ST_SEARCH;
                        good_cnt_d = CNT_ZERO;
                        bad_cnt_d  = CNT_ZERO;
                    end else begin
                        bad_cnt_d = bad_inc_s;
                    end
                end else if (word_good_s) begin
                    bad_cnt_d = CNT_ZERO;
                end else begin
                    bad_cnt_d = bad_cnt_q;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                good_cnt_d = CNT_ZERO;
                bad_cnt_d  = CNT_ZERO;
            end
        endcase
    end

    // Error counter: counts visible wa_error pulses; a clear in the same
    // cycle as a pulse wins.
    always_comb begin
        if (clr_err_cnt) begin
            err_cnt_d = CNT_ZERO;
        end else if (wa_error_q && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + CNT_ONE;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            good_cnt_q   <= CNT_ZERO;
            bad_cnt_q    <= CNT_ZERO;
            err_cnt_q    <= CNT_ZERO;
            wa_error_q   <= 1'b0;
            align_done_q <= 1'b0;
            dout_vld_q   <= 1'b0;
            dout_q       <= '0;
        end else begin
            state_q      <= state_d;
            good_cnt_q   <= good_cnt_d;
            bad_cnt_q    <= bad_cnt_d;
            err_cnt_q    <= err_cnt_d;
            wa_error_q   <= wa_error_d;
            // Tracks the state register exactly, no input-to-output path.
            align_done_q <= (state_d == ST_LOCKED);
            dout_vld_q   <= data_vld & (state_q == ST_LOCKED);
            if (data_vld) begin
                dout_q <= data_out;
            end else begin
                dout_q <= dout_q;
            end
        end
    end

    assign m_rxfifo_align_done = align_done_q;
    assign wa_error            = wa_error_q;
    assign wa_error_cnt        = err_cnt_q;
    assign dout                = dout_q;
    assign dout_vld            = dout_vld_q;

endmodule : mac_rx_align_chk

// File: tb/tb_mac_rx_align_chk.sv
// -----------------------------------------------------------------------------
// tb_mac_rx_align_chk
// Directed scenarios followed by random traffic. A behavioural model tracks
// "transfer active", "aligned", the current good/bad run lengths and the error
// tally, and every cycle all outputs are compared against it.
// -----------------------------------------------------------------------------
module tb_mac_rx_align_chk;

    localparam int DW = 40;
    localparam int W  = 2*DW;
    localparam int LOCK_N   = 4;
    localparam int UNLOCK_N = 3;

    logic          rd_clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_transfer_en = 1'b0;
    logic          data_vld = 1'b0;
    logic [W-1:0]  data_out = '0;
    logic          clr_err_cnt = 1'b0;
    logic          m_rxfifo_align_done;
    logic          wa_error;
    logic [3:0]    wa_error_cnt;
    logic [W-1:0]  dout;
    logic          dout_vld;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    bit           m_active;
    bit           m_aligned;
    int           m_good_run;
    int           m_bad_run;
    int           m_errs;
    bit           m_pulse;
    bit           m_dvld;
    logic [W-1:0] m_dout;

    mac_rx_align_chk #(
        .DWIDTH     (DW),
        .LOCK_CNT   (LOCK_N),
        .UNLOCK_CNT (UNLOCK_N)
    ) dut (
        .rd_clk              (rd_clk),
        .rst                 (rst),
        .rx_transfer_en      (rx_transfer_en),
        .data_vld            (data_vld),
        .data_out            (data_out),
        .clr_err_cnt         (clr_err_cnt),
        .m_rxfifo_align_done (m_rxfifo_align_done),
        .wa_error            (wa_error),
        .wa_error_cnt        (wa_error_cnt),
        .dout                (dout),
        .dout_vld            (dout_vld)
    );

    always #5 rd_clk = ~rd_clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mk_word(input bit good);
        logic [95:0]  r;
        logic [W-1:0] w;
        r = {$urandom, $urandom, $urandom};
        w = r[W-1:0];
        if (good) begin
            w[W-1]  = 1'b1;
            w[DW-1] = 1'b0;
        end else begin
            case ($urandom_range(0, 2))
                0:       begin w[W-1] = 1'b0; w[DW-1] = 1'b0; end
                1:       begin w[W-1] = 1'b1; w[DW-1] = 1'b1; end
                default: begin w[W-1] = 1'b0; w[DW-1] = 1'b1; end
            endcase
        end
        return w;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_tick();
        bit good;
        bit pulse_n;
        if (rst) begin
            m_active = 0; m_aligned = 0; m_good_run = 0; m_bad_run = 0;
            m_errs = 0; m_pulse = 0; m_dvld = 0; m_dout = '0;
        end else begin
            good = data_vld && data_out[W-1] && !data_out[DW-1];
            m_dvld = data_vld && m_aligned;
            if (data_vld) m_dout = data_out;
            if (clr_err_cnt) m_errs = 0;
            else if (m_pulse && m_errs < 15) m_errs++;
            pulse_n = rx_transfer_en && m_active && m_aligned && data_vld && !good;
            if (!rx_transfer_en) begin
                m_active = 0; m_aligned = 0; m_good_run = 0; m_bad_run = 0;
            end else if (!m_active) begin
                m_active = 1;
            end else if (data_vld) begin
                if (!m_aligned) begin
                    m_good_run = good ? m_good_run + 1 : 0;
                    if (m_good_run == LOCK_N) begin
                        m_aligned = 1; m_good_run = 0;
                    end
                end else begin
                    m_bad_run = good ? 0 : m_bad_run + 1;
                    if (m_bad_run == UNLOCK_N) begin
                        m_aligned = 0; m_bad_run = 0; m_good_run = 0;
                    end
                end
            end
            m_pulse = pulse_n;
        end
    endtask

    // Drive one cycle, clock it, then compare every output with the model.
    task automatic step(input bit r, input bit en, input bit vld, input logic [W-1:0] d, input bit clr);
        rst = r; rx_transfer_en = en; data_vld = vld; data_out = d; clr_err_cnt = clr;
        model_tick();
        @(posedge rd_clk);
        #1;
        chk("align_done", W'(m_rxfifo_align_done), W'(m_aligned));
        chk("wa_error", W'(wa_error), W'(m_pulse));
        chk("wa_error_cnt", W'(wa_error_cnt), W'(m_errs));
        chk("dout", dout, m_dout);
        chk("dout_vld", W'(dout_vld), W'(m_dvld));
    endtask

    task automatic good_w();  step(0, 1, 1, mk_word(1), 0); endtask
    task automatic bad_w();   step(0, 1, 1, mk_word(0), 0); endtask
    task automatic idle_w();  step(0, 1, 0, mk_word(1), 0); endtask

    int pulses;

    initial begin
        // Reset
        step(1, 0, 0, '0, 0);
        chk("rst_align", W'(m_rxfifo_align_done), W'(0));
        chk("rst_dout", dout, '0);
        chk("rst_cnt", W'(wa_error_cnt), W'(0));

        // Basic lock: 4 good words, dout_vld on the 5th
        idle_w();
        for (int i = 0; i < 3; i++) good_w();
        chk("lock_early", W'(m_rxfifo_align_done), W'(0));
        good_w();
        chk("lock_4th", W'(m_rxfifo_align_done), W'(1));
        chk("dvld_4th", W'(dout_vld), W'(0));
        good_w();
        chk("dvld_5th", W'(dout_vld), W'(1));

        // LOCKED: bad,good,bad,bad,bad
        pulses = 0;
        bad_w();  pulses += int'(wa_error);
        good_w(); pulses += int'(wa_error);
        bad_w();  pulses += int'(wa_error);
        bad_w();  pulses += int'(wa_error);
        chk("unlock_pre", W'(m_rxfifo_align_done), W'(1));
        bad_w();  pulses += int'(wa_error);
        chk("unlock_post", W'(m_rxfifo_align_done), W'(0));
        chk("unlock_pulses", W'(pulses), W'(4));
        idle_w();
        chk("unlock_cnt", W'(wa_error_cnt), W'(4));

        // SEARCH: good x3, bad, good x4
        for (int i = 0; i < 3; i++) good_w();
        bad_w();
        for (int i = 0; i < 3; i++) good_w();
        chk("search_nolock", W'(m_rxfifo_align_done), W'(0));
        good_w();
        chk("search_lock", W'(m_rxfifo_align_done), W'(1));

        // Saturation and coincident clear
        for (int i = 0; i < 20; i++) begin bad_w(); good_w(); end
        chk("sat_cnt", W'(wa_error_cnt), W'(15));
        chk("sat_locked", W'(m_rxfifo_align_done), W'(1));
        bad_w();
        chk("sat_pulse", W'(wa_error), W'(1));
        step(0, 1, 1, mk_word(1), 1);
        chk("clr_coinc", W'(wa_error_cnt), W'(0));
        idle_w();
        chk("clr_hold", W'(wa_error_cnt), W'(0));

        // rx_transfer_en drop for one cycle
        bad_w(); good_w();
        step(0, 0, 0, '0, 0);
        chk("en_drop_align", W'(m_rxfifo_align_done), W'(0));
        chk("en_drop_cnt", W'(wa_error_cnt), W'(1));
        idle_w();
        for (int i = 0; i < 3; i++) good_w();
        chk("relock_early", W'(m_rxfifo_align_done), W'(0));
        good_w();
        chk("relock", W'(m_rxfifo_align_done), W'(1));
        chk("relock_cnt", W'(wa_error_cnt), W'(1));

        // Reset mid-LOCKED with valid data
        good_w();
        step(1, 1, 1, mk_word(1), 0);
        chk("midrst_align", W'(m_rxfifo_align_done), W'(0));
        chk("midrst_dvld", W'(dout_vld), W'(0));
        chk("midrst_dout", dout, '0);
        chk("midrst_cnt", W'(wa_error_cnt), W'(0));

        // Gaps in SEARCH keep the good count
        idle_w();
        good_w(); idle_w(); good_w(); idle_w(); idle_w(); good_w();
        chk("gap_nolock", W'(m_rxfifo_align_done), W'(0));
        good_w();
        chk("gap_lock", W'(m_rxfifo_align_done), W'(1));

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit r, en, vld, clr, g;
            r   = ($urandom_range(0, 399) == 0);
            en  = ($urandom_range(0, 24) != 0);
            vld = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 29) == 0);
            g   = (i % 400 < 200) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 5);
            step(r, en, vld, mk_word(g), clr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_mac_rx_align_chk
